// File: rtl/demux_pkg.sv
// Shared defaults and state encoding for the demux select sequencer.
package demux_pkg;
    localparam int NCH_DEF  = 8;
    localparam int SELW_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;
endpackage

// File: rtl/demux_hold_timer.sv
// Per-channel hold counter; expire is high on the last cycle a channel is held.
module demux_hold_timer #(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == CW'(HOLD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expire)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/demux_sel_sequencer.sv
// Serialises one NCH-bit word onto dout while stepping sel across the demux
// channels, holding each channel for HOLD cycles.
module demux_sel_sequencer
    import demux_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int SELW = SELW_DEF,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NCH-1:0]  in_data,
    input  logic            abort,
    output logic            dout,
    output logic [SELW-1:0] sel,
    output logic            ch_valid,
    output logic            busy,
    output logic            frame_done
);
    state_t          state_q, state_d;
    logic [NCH-1:0]  shreg_q, shreg_d;
    logic [SELW-1:0] sel_q, sel_d, sel_nxt;
    logic            dout_q, dout_d;
    logic            chv_q, chv_d;
    logic            done_q, done_d;
    logic            tmr_en, tmr_clr, expire;

    // Timer only runs while a channel is live; any channel change restarts it.
    assign tmr_en  = (state_q == DRIVE) && !abort;
    assign tmr_clr = !tmr_en || expire;

    demux_hold_timer #(.HOLD(HOLD)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .expire (expire)
    );

    assign sel_nxt = sel_q + 1'b1;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        chv_d   = chv_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    sel_d   = '0;
                    dout_d  = in_data[0];
                    chv_d   = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (abort || (expire && sel_q == SELW'(NCH - 1))) begin
                    // Abort wins over completion, so it never raises frame_done.
                    state_d = IDLE;
                    sel_d   = '0;
                    dout_d  = 1'b0;
                    chv_d   = 1'b0;
                    done_d  = !abort;
                end else if (expire) begin
                    sel_d  = sel_nxt;
                    dout_d = shreg_q[sel_nxt];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            sel_q   <= '0;
            dout_q  <= 1'b0;
            chv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            chv_q   <= chv_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == DRIVE);
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign ch_valid   = chv_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench: two sequencers (HOLD=1 and HOLD=3) checked every cycle against a
// frame-position model, plus directed literal expectations.
module tb_demux_sel_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid [2];
    logic [7:0] in_data  [2];
    logic       abort    [2];
    logic       in_ready [2];
    logic       dout     [2];
    logic [2:0] sel      [2];
    logic       ch_valid [2];
    logic       busy     [2];
    logic       frame_done [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_sel_sequencer #(.NCH(8), .SELW(3), .HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .abort(abort[0]), .dout(dout[0]), .sel(sel[0]),
        .ch_valid(ch_valid[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    demux_sel_sequencer #(.NCH(8), .SELW(3), .HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .abort(abort[1]), .dout(dout[1]), .sel(sel[1]),
        .ch_valid(ch_valid[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a frame is just (word, driven-cycle index t); channel = t / HOLD.
    int         H [2] = '{1, 3};
    logic       m_act  [2] = '{1'b0, 1'b0};
    logic [7:0] m_word [2] = '{8'h0, 8'h0};
    int         m_t    [2] = '{0, 0};
    logic       m_done [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_t[i]    <= 0;
            end else if (!m_act[i]) begin
                m_done[i] <= 1'b0;
                if (in_valid[i]) begin
                    m_act[i]  <= 1'b1;
                    m_word[i] <= in_data[i];
                    m_t[i]    <= 0;
                end
            end else if (abort[i]) begin
                m_act[i]  <= 1'b0;
                m_done[i] <= 1'b0;
            end else if (m_t[i] == 8 * H[i] - 1) begin
                m_act[i]  <= 1'b0;
                m_done[i] <= 1'b1;
            end else begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         ch;
            logic [7:0] expv, gotv;
            ch   = m_act[i] ? m_t[i] / H[i] : 0;
            expv = {~m_act[i], m_act[i], m_act[i], m_done[i],
                    m_act[i] ? m_word[i][ch] : 1'b0, 3'(ch)};
            gotv = {in_ready[i], busy[i], ch_valid[i], frame_done[i], dout[i], sel[i]};
            chk(i == 0 ? "model_h1 {rdy,busy,chv,done,dout,sel}" : "model_h3 {rdy,busy,chv,done,dout,sel}",
                32'(gotv), 32'(expv));
        end
    end

    // Presents a word for one edge; returns #1 into cycle 1 of the frame.
    task automatic go(input int i, input logic [7:0] d);
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (!in_ready[i] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    logic [7:0] a5_bits;

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 8'h0; abort[i] = 1'b0;
        end
        #2;
        chk("reset_in_ready", 32'(in_ready[0]), 32'd1);
        chk("reset_chv_sel", 32'({ch_valid[0], sel[0], dout[0], busy[0]}), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // HOLD=1, 8'hA5: dout follows bits 0..7 = 1,0,1,0,0,1,0,1
        a5_bits = 8'b1010_0101;
        go(0, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("a5_sel", 32'(sel[0]), 32'(k));
            chk("a5_dout", 32'(dout[0]), 32'(a5_bits[k]));
            chk("a5_chv", 32'(ch_valid[0]), 32'd1);
        end
        @(negedge clk);
        chk("a5_done", 32'({frame_done[0], in_ready[0], ch_valid[0]}), 32'b110);
        @(posedge clk); #1;

        // HOLD=3, 8'h01: dout=1 only on channel 0, frame_done in cycle 25
        go(1, 8'h01);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            chk("h3_sel", 32'(sel[1]), 32'((c - 1) / 3));
            chk("h3_dout", 32'(dout[1]), 32'(c <= 3));
        end
        @(negedge clk);
        chk("h3_done", 32'({frame_done[1], ch_valid[1]}), 32'b10);
        @(posedge clk); #1;

        // Back-to-back with in_valid held high
        in_valid[0] = 1'b1; in_data[0] = 8'hFF;
        @(posedge clk); #1;
        in_data[0] = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("b2b_ready_low", 32'(in_ready[0]), 32'd0);
        end
        @(negedge clk);
        chk("b2b_gap", 32'({in_ready[0], frame_done[0]}), 32'b11);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_second", 32'({sel[0], dout[0], ch_valid[0]}), 32'b000_0_1);
        @(posedge clk); #1;
        wait_idle(0);

        // Abort while sel=3, then restart at sel=0
        go(0, 8'hFF);
        repeat (3) @(posedge clk); #1;
        chk("abort_at_sel3", 32'(sel[0]), 32'd3);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_idle", 32'({ch_valid[0], sel[0], in_ready[0], frame_done[0]}), 32'b0_000_1_0);
        go(0, 8'h80);
        chk("restart", 32'({sel[0], dout[0], ch_valid[0]}), 32'b000_0_1);
        wait_idle(0);

        // Abort on the final hold cycle of sel=7 (HOLD=3)
        go(1, 8'hFF);
        repeat (23) @(posedge clk); #1;
        chk("last_hold_sel", 32'(sel[1]), 32'd7);
        abort[1] = 1'b1;
        @(posedge clk); #1;
        chk("abort_last", 32'({frame_done[1], in_ready[1], ch_valid[1]}), 32'b010);
        // abort held in IDLE, alongside in_valid: accept still happens
        in_valid[1] = 1'b1; in_data[1] = 8'h03;
        @(posedge clk); #1;
        in_valid[1] = 1'b0; abort[1] = 1'b0;
        chk("abort_idle_ignored", 32'({ch_valid[1], sel[1], dout[1]}), 32'b1_000_1);
        wait_idle(1);

        // Reset mid-frame at sel=4
        go(0, 8'hFF);
        repeat (4) @(posedge clk); #1;
        chk("pre_reset_sel", 32'(sel[0]), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({sel[0], dout[0], ch_valid[0], busy[0]}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset", 32'({in_ready[0], frame_done[0]}), 32'b10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
